gray_checker: RTL and testbench
===============================

# gray_checker

Downstream monitor for the 3-bit Gray counter. Samples the counter's Gray output every clock, converts it to binary, counts completed laps (7→0 wraps), and detects illegal code transitions. It sits directly after the counter and gives the rest of the design a registered binary value, a lap count and a sticky fault flag.

## Interface
- LAP_W, 8, width of lap counter (saturating)
- ERR_W, 4, width of illegal-transition counter (saturating)

- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous clear of laps/fault/error count; returns FSM to IDLE
- Gray  in  3  Gray code from counter
- Bin  out  3  registered binary equivalent of last accepted Gray sample
- Laps  out  LAP_W  number of 100→000 wraps seen in TRACK, saturates at all-ones
- Wrap  out  1  one-cycle pulse in the cycle Laps is updated by a wrap
- Resync  out  1  one-cycle pulse when a non-wrap jump to 000 is accepted
- Fault  out  1  sticky; high while FSM is in FAULT
- ErrCount  out  ERR_W  illegal transitions seen, saturating
- Valid  out  1  high once at least one sample has been accepted since reset/Clear

## Operation
- Decode: b2=g2, b1=g2^g1, b0=b1^g0. Legal sequence 000,001,011,010,110,111,101,100,000…
- Internal register Prev[2:0] holds last accepted Gray sample.
- FSM states IDLE, TRACK, FAULT; reset state IDLE.
- IDLE: on every clock (Clear low) capture Gray into Prev, load Bin, set Valid, go TRACK. No check on the first sample.
- TRACK, classifying Gray against Prev each clock:
  - Gray==Prev: hold; no output change.
  - Gray==next(Prev), Prev≠100: step; Prev/Bin update.
  - Prev==100, Gray==000: wrap; update, Laps+1 (saturate), Wrap pulse.
  - Gray==000, Prev∉{000,100}: counter reset; update, Resync pulse, no error.
  - Anything else: illegal; ErrCount+1 (saturate), go FAULT; Prev/Bin still load the new sample.
- FAULT: Prev/Bin keep following Gray every clock without checking; Laps frozen; Wrap/Resync stay 0; ErrCount not incremented further. Exit only by Clear or Reset.
- Clear (any state, priority over all classification): next clock Laps=0, ErrCount=0, Fault=0, Valid=0, Wrap=Resync=0, FSM=IDLE. Bin and Prev keep value.
- Reset low (asynchronous, any time): all outputs and Prev to 0, FSM IDLE, immediately, independent of Clk.

## Timing
- Reset values: Bin=0, Laps=0, Wrap=0, Resync=0, Fault=0, ErrCount=0, Valid=0.
- Latency: Gray sampled at edge N appears on Bin after edge N (1 cycle). Laps/Wrap/Resync/Fault/ErrCount change on the same edge as Bin.
- Wrap and Resync are exactly one cycle wide; a new qualifying event on the next edge produces another pulse.
- Laps at all-ones: wrap still pulses Wrap, Laps holds.
- Reset release: first rising edge with Reset high is an IDLE capture.
- Clear and an illegal transition on the same edge: Clear wins, no error counted.

## Test plan
- Reset low 20 ns, then Gray steps 000→001→…→100 one per clock: Bin=0..7, Fault=0, Valid=1 after first edge, ErrCount=0.
- 3 full laps (24 steps from 000): exactly 3 Wrap pulses, Laps=3; Gray held 5 cycles mid-lap → no change.
- Gray 011→000 (counter reset mid-lap): Resync pulse 1 cycle, Bin=0, Laps unchanged, Fault=0.
- Gray 001→010 (illegal): after edge Fault=1, ErrCount=1, Bin=3; later 100→000 gives no Wrap; then Clear 1 cycle → Fault=0, ErrCount=0, Laps=0, Valid=0, next edge Valid=1.
- LAP_W=2, 5 laps: Laps reaches 3 and holds, Wrap pulses 5 times.
- Reset asserted between edges mid-lap: outputs 0 immediately (before next Clk edge); release → first edge captures without error.

Source files
------------

// File: rtl/gray_checker.sv
// Monitors a 3-bit Gray counter: registered binary decode, saturating lap count,
// wrap/resync pulses and a sticky fault with saturating illegal-transition count.
module gray_checker #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [2:0]       gray,
  output logic [2:0]       bin,
  output logic [LAP_W-1:0] laps,
  output logic             wrap,
  output logic             resync,
  output logic             fault,
  output logic [ERR_W-1:0] err_count,
  output logic             valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       prev, prev_nxt;
  logic [2:0]       bin_nxt;
  logic [LAP_W-1:0] laps_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             wrap_nxt, resync_nxt, valid_nxt;
  logic [2:0]       prev_bin_inc;
  logic [2:0]       gray_expected;

  function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
    return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
  endfunction

  assign prev_bin_inc  = gray_to_bin(prev) + 3'd1;
  assign gray_expected = prev_bin_inc ^ (prev_bin_inc >> 1);
  assign fault         = (state == FAULT);

  always_comb begin
    state_nxt  = state;
    prev_nxt   = prev;
    bin_nxt    = bin;
    laps_nxt   = laps;
    err_nxt    = err_count;
    valid_nxt  = valid;
    wrap_nxt   = 1'b0;
    resync_nxt = 1'b0;
    if (clear) begin
      // Bin/Prev deliberately keep their value across a clear
      state_nxt = IDLE;
      laps_nxt  = '0;
      err_nxt   = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          prev_nxt  = gray;
          bin_nxt   = gray_to_bin(gray);
          valid_nxt = 1'b1;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (gray != prev) begin
            prev_nxt = gray;
            bin_nxt  = gray_to_bin(gray);
            if (prev == 3'b100 && gray == 3'b000) begin
              wrap_nxt = 1'b1;
              if (laps != '1) laps_nxt = laps + LAP_W'(1);
            end else if (gray == gray_expected) begin
              // ordinary single step
            end else if (gray == 3'b000) begin
              resync_nxt = 1'b1;
            end else begin
              if (err_count != '1) err_nxt = err_count + ERR_W'(1);
              state_nxt = FAULT;
            end
          end
        end
        FAULT: begin
          prev_nxt = gray;
          bin_nxt  = gray_to_bin(gray);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= 3'b000;
      bin       <= 3'b000;
      laps      <= '0;
      err_count <= '0;
      valid     <= 1'b0;
      wrap      <= 1'b0;
      resync    <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      bin       <= bin_nxt;
      laps      <= laps_nxt;
      err_count <= err_nxt;
      valid     <= valid_nxt;
      wrap      <= wrap_nxt;
      resync    <= resync_nxt;
    end
  end

endmodule

// File: tb/tb_gray_checker.sv
// Directed bench for gray_checker: default instance plus a LAP_W=2 instance for saturation.
module tb_gray_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, clear2;
  logic [2:0] gray, gray2;

  logic [2:0] bin, bin2;
  logic [7:0] laps;
  logic [1:0] laps2;
  logic       wrap, wrap2, resync, resync2, fault, fault2, valid, valid2;
  logic [3:0] err_count, err_count2;

  int total = 0;
  int bad   = 0;

  logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  always #5 clk = ~clk;

  gray_checker #(.LAP_W(8), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .gray(gray),
    .bin(bin), .laps(laps), .wrap(wrap), .resync(resync),
    .fault(fault), .err_count(err_count), .valid(valid)
  );

  gray_checker #(.LAP_W(2), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear2), .gray(gray2),
    .bin(bin2), .laps(laps2), .wrap(wrap2), .resync(resync2),
    .fault(fault2), .err_count(err_count2), .valid(valid2)
  );

  // One edge, then settle to the falling edge where outputs are observed.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; clear2 = 1'b0; gray = 3'b000; gray2 = 3'b000;
    repeat (2) @(negedge clk);
    total++;
    if ({bin, laps, wrap, resync, fault, err_count, valid} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got bin=%0d laps=%0d wrap=%b resync=%b fault=%b err=%0d valid=%b exp all 0",
               bin, laps, wrap, resync, fault, err_count, valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    gray = 3'b000;
    cyc();
    total++;
    if (valid !== 1'b1 || bin !== 3'd0) begin
      bad++; $display("FAIL first_capture got valid=%b bin=%0d exp valid=1 bin=0", valid, bin);
    end
    for (int i = 1; i < 8; i++) begin
      gray = gseq[i];
      cyc();
      total++;
      if (bin !== 3'(i) || fault !== 1'b0 || err_count !== 4'd0 || valid !== 1'b1) begin
        bad++;
        $display("FAIL count_step%0d got bin=%0d fault=%b err=%0d valid=%b exp bin=%0d fault=0 err=0 valid=1",
                 i, bin, fault, err_count, valid, i);
      end
    end
  endtask

  task automatic test_laps();
    int wraps = 0;
    for (int i = 0; i < 24; i++) begin
      gray = gseq[i % 8];
      cyc();
      if (wrap === 1'b1) wraps++;
      total++;
      if (bin !== 3'(i % 8) || wrap !== ((i % 8) == 0)) begin
        bad++;
        $display("FAIL lap_step%0d got bin=%0d wrap=%b exp bin=%0d wrap=%b", i, bin, wrap, i % 8, (i % 8) == 0);
      end
      if (i == 12) begin
        for (int h = 0; h < 5; h++) begin
          cyc();
          total++;
          if (bin !== 3'd4 || wrap !== 1'b0 || resync !== 1'b0 || laps !== 8'd2 || fault !== 1'b0) begin
            bad++;
            $display("FAIL hold%0d got bin=%0d wrap=%b resync=%b laps=%0d fault=%b exp bin=4 wrap=0 resync=0 laps=2 fault=0",
                     h, bin, wrap, resync, laps, fault);
          end
        end
      end
    end
    total++;
    if (wraps != 3 || laps !== 8'd3) begin
      bad++; $display("FAIL three_laps got wraps=%0d laps=%0d exp wraps=3 laps=3", wraps, laps);
    end
  endtask

  task automatic test_resync();
    gray = 3'b000; cyc();
    gray = 3'b001; cyc();
    gray = 3'b011; cyc();
    total++;
    if (laps !== 8'd4 || bin !== 3'd2) begin
      bad++; $display("FAIL pre_resync got laps=%0d bin=%0d exp laps=4 bin=2", laps, bin);
    end
    gray = 3'b000; cyc();
    total++;
    if (resync !== 1'b1 || bin !== 3'd0 || laps !== 8'd4 || fault !== 1'b0 || wrap !== 1'b0 || err_count !== 4'd0) begin
      bad++;
      $display("FAIL resync got resync=%b bin=%0d laps=%0d fault=%b wrap=%b err=%0d exp 1,0,4,0,0,0",
               resync, bin, laps, fault, wrap, err_count);
    end
    cyc();
    total++;
    if (resync !== 1'b0) begin
      bad++; $display("FAIL resync_width got resync=%b exp 0", resync);
    end
  endtask

  task automatic test_illegal();
    gray = 3'b001; cyc();
    gray = 3'b010; cyc();
    total++;
    if (fault !== 1'b1 || err_count !== 4'd1 || bin !== 3'd3) begin
      bad++; $display("FAIL illegal got fault=%b err=%0d bin=%0d exp fault=1 err=1 bin=3", fault, err_count, bin);
    end
    gray = 3'b110; cyc();
    gray = 3'b111; cyc();
    gray = 3'b101; cyc();
    gray = 3'b100; cyc();
    gray = 3'b000; cyc();
    total++;
    if (wrap !== 1'b0 || laps !== 8'd4 || bin !== 3'd0 || fault !== 1'b1 || err_count !== 4'd1) begin
      bad++;
      $display("FAIL fault_wrap got wrap=%b laps=%0d bin=%0d fault=%b err=%0d exp wrap=0 laps=4 bin=0 fault=1 err=1",
               wrap, laps, bin, fault, err_count);
    end
    gray = 3'b111; cyc();
    total++;
    if (err_count !== 4'd1 || bin !== 3'd5 || resync !== 1'b0) begin
      bad++; $display("FAIL fault_follow got err=%0d bin=%0d resync=%b exp err=1 bin=5 resync=0", err_count, bin, resync);
    end
    clear = 1'b1; gray = 3'b101; cyc();
    total++;
    if (fault !== 1'b0 || err_count !== 4'd0 || laps !== 8'd0 || valid !== 1'b0 || bin !== 3'd5) begin
      bad++;
      $display("FAIL clear got fault=%b err=%0d laps=%0d valid=%b bin=%0d exp fault=0 err=0 laps=0 valid=0 bin=5",
               fault, err_count, laps, valid, bin);
    end
    clear = 1'b0; cyc();
    total++;
    if (valid !== 1'b1 || bin !== 3'd6 || fault !== 1'b0 || err_count !== 4'd0) begin
      bad++; $display("FAIL after_clear got valid=%b bin=%0d fault=%b err=%0d exp valid=1 bin=6 fault=0 err=0",
                      valid, bin, fault, err_count);
    end
  endtask

  task automatic test_clear_vs_illegal();
    clear = 1'b1; gray = 3'b010; cyc();
    total++;
    if (err_count !== 4'd0 || fault !== 1'b0 || valid !== 1'b0 || bin !== 3'd6) begin
      bad++; $display("FAIL clear_wins got err=%0d fault=%b valid=%b bin=%0d exp err=0 fault=0 valid=0 bin=6",
                      err_count, fault, valid, bin);
    end
    clear = 1'b0; cyc();
    total++;
    if (bin !== 3'd3 || valid !== 1'b1 || err_count !== 4'd0 || fault !== 1'b0) begin
      bad++; $display("FAIL recapture got bin=%0d valid=%b err=%0d fault=%b exp bin=3 valid=1 err=0 fault=0",
                      bin, valid, err_count, fault);
    end
  endtask

  task automatic test_saturate();
    int wraps = 0;
    clear2 = 1'b1; gray2 = 3'b000; cyc();
    clear2 = 1'b0; cyc();
    for (int lap = 0; lap < 5; lap++) begin
      for (int i = 1; i <= 8; i++) begin
        gray2 = gseq[i % 8];
        cyc();
        if (wrap2 === 1'b1) wraps++;
      end
      total++;
      if (laps2 !== ((lap >= 2) ? 2'd3 : 2'(lap + 1))) begin
        bad++; $display("FAIL sat_lap%0d got laps=%0d exp %0d", lap, laps2, (lap >= 2) ? 3 : lap + 1);
      end
    end
    total++;
    if (wraps != 5 || fault2 !== 1'b0) begin
      bad++; $display("FAIL sat_wraps got wraps=%0d fault=%b exp wraps=5 fault=0", wraps, fault2);
    end
  endtask

  task automatic test_async_reset();
    gray = 3'b110; cyc();
    gray = 3'b111; cyc();
    gray = 3'b101; cyc();
    gray = 3'b100; cyc();
    gray = 3'b000; cyc();
    gray = 3'b001; cyc();
    gray = 3'b011; cyc();
    total++;
    if (laps !== 8'd1 || bin !== 3'd2) begin
      bad++; $display("FAIL pre_reset got laps=%0d bin=%0d exp laps=1 bin=2", laps, bin);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bin, laps, wrap, resync, fault, err_count, valid} !== 20'd0) begin
      bad++; $display("FAIL async_reset got bin=%0d laps=%0d valid=%b exp all 0", bin, laps, valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    total++;
    if (bin !== 3'd2 || valid !== 1'b1 || fault !== 1'b0 || err_count !== 4'd0) begin
      bad++; $display("FAIL release_capture got bin=%0d valid=%b fault=%b err=%0d exp bin=2 valid=1 fault=0 err=0",
                      bin, valid, fault, err_count);
    end
    gray = 3'b010; cyc();
    total++;
    if (bin !== 3'd3 || fault !== 1'b0 || err_count !== 4'd0) begin
      bad++; $display("FAIL release_step got bin=%0d fault=%b err=%0d exp bin=3 fault=0 err=0", bin, fault, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_laps();
    test_resync();
    test_illegal();
    test_clear_vs_illegal();
    test_saturate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
